// File: rtl/seq_divider_32.sv
// Signed 32-bit restoring divider, one quotient bit per clock.
// Remainder takes the dividend's sign; quotient truncates toward zero.
module seq_divider_32 #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic [2*WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIX,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sgnq_q, sgnq_d;
  logic             sgnr_q, sgnr_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;
  logic             neg;
  logic             zero_dvs;

  assign zero_dvs = (divisor == '0);
  assign shifted  = {rem_q, dvd_q[WIDTH-1]};
  assign trial    = shifted - {2'b00, dvs_q};
  assign neg      = trial[WIDTH+1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = zero_dvs ? DONE : ITER;
      ITER: if (cnt_q == CW'(WIDTH-1)) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  // Operands are stored as magnitudes; signs are reapplied in FIX.
  always_comb begin
    dvd_d  = dvd_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    sgnq_d = sgnq_q;
    sgnr_d = sgnr_q;
    quo_d  = quo_q;
    rmd_d  = rmd_q;
    dbz_d  = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sgnq_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          sgnr_d = dividend[WIDTH-1];
          dvd_d  = dividend[WIDTH-1] ? -dividend : dividend;
          dvs_d  = divisor[WIDTH-1] ? -divisor : divisor;
          rem_d  = '0;
          cnt_d  = '0;
          dbz_d  = zero_dvs;
          if (zero_dvs) begin
            quo_d = '1;
            rmd_d = dividend;
          end
        end
      end
      ITER: begin
        dvd_d = {dvd_q[WIDTH-2:0], ~neg};
        rem_d = neg ? shifted[WIDTH:0] : trial[WIDTH:0];
        cnt_d = cnt_q + 1'b1;
      end
      FIX: begin
        quo_d = sgnq_q ? -dvd_q : dvd_q;
        rmd_d = sgnr_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dvd_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      sgnq_q <= 1'b0;
      sgnr_q <= 1'b0;
      quo_q  <= '0;
      rmd_q  <= '0;
      dbz_q  <= 1'b0;
    end else begin
      dvd_q  <= dvd_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      sgnq_q <= sgnq_d;
      sgnr_q <= sgnr_d;
      quo_q  <= quo_d;
      rmd_q  <= rmd_d;
      dbz_q  <= dbz_d;
    end
  end

  assign quotient    = quo_q;
  assign remainder   = rmd_q;
  assign div_by_zero = dbz_q;
  assign result      = {rmd_q, quo_q};

endmodule

// File: tb/tb_seq_divider_32.sv
// Bench for seq_divider_32: directed table, corner sequences
// and random operands checked against an arithmetic model.
module tb_seq_divider_32;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic [63:0] result;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seq_divider_32 #(.WIDTH(32)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .div_by_zero(div_by_zero),
    .quotient(quotient),
    .remainder(remainder),
    .result(result)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r,
                                output logic z);
    longint sa, sb, qq, rr;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      z = 1'b1;
    end else begin
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
      qq = sa / sb;
      rr = sa % sb;
      q  = qq[31:0];
      r  = rr[31:0];
      z  = 1'b0;
    end
  endfunction

  // Drives start for one edge (E0) and returns #1 after it.
  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int lat0, output int lat, output bit bok);
    lat = lat0;
    bok = 1'b1;
    while (!done && lat < 40) begin
      if (!busy) bok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    if (!busy) bok = 1'b0;
  endtask

  task automatic finish_op(input string nm, input logic [31:0] b,
                           input int lat0, input logic [31:0] eq,
                           input logic [31:0] er, input logic ez);
    int lat;
    bit bok;
    wait_done(lat0, lat, bok);
    chk({nm, " done"}, done, 1'b1);
    chk({nm, " latency"}, lat, (b == 32'd0) ? 0 : 33);
    chk({nm, " busy"}, bok, 1'b1);
    chk({nm, " quotient"}, quotient, eq);
    chk({nm, " remainder"}, remainder, er);
    chk({nm, " result"}, result, {er, eq});
    chk({nm, " dbz"}, div_by_zero, ez);
    @(posedge clk);
    #1;
    chk({nm, " idle"}, {busy, done}, 2'b00);
  endtask

  task automatic run_vec(input string nm, input vec_t v);
    launch(v.a, v.b);
    finish_op(nm, v.b, 0, v.q, v.r, v.z);
  endtask

  initial begin
    logic [31:0] a, b, eq, er;
    logic        ez;
    bit          saw_done;
    int          sel;

    vecs.push_back('{32'd100, 32'd7, 32'd14, 32'd2, 1'b0});
    vecs.push_back('{-32'sd100, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0});
    vecs.push_back('{32'd100, -32'sd7, 32'hFFFF_FFF2, 32'd2, 1'b0});
    vecs.push_back('{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0});
    vecs.push_back('{32'h8000_0000, 32'd2, 32'hC000_0000, 32'd0, 1'b0});
    vecs.push_back('{32'd0, 32'd5, 32'd0, 32'd0, 1'b0});
    vecs.push_back('{32'd7, 32'd100, 32'd0, 32'd7, 1'b0});
    vecs.push_back('{-32'sd7, 32'd100, 32'd0, 32'hFFFF_FFF9, 1'b0});
    vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0});
    vecs.push_back('{32'h7FFF_FFFF, 32'd1, 32'h7FFF_FFFF, 32'd0, 1'b0});
    vecs.push_back('{32'h8000_0000, 32'h8000_0000, 32'd1, 32'd0, 1'b0});
    vecs.push_back('{32'd5, 32'h8000_0000, 32'd0, 32'd5, 1'b0});
    vecs.push_back('{32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1});

    reset    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #2;
    chk("reset outs", {busy, done, div_by_zero}, 3'b000);
    chk("reset result", result, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);

    // divide by zero, hold, then cleared by next accepted start
    launch(32'd55, 32'd0);
    finish_op("dbz55", 32'd0, 0, 32'hFFFF_FFFF, 32'd55, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    chk("dbz hold", {div_by_zero, quotient}, {1'b1, 32'hFFFF_FFFF});
    launch(32'd9, 32'd3);
    chk("dbz clear", div_by_zero, 1'b0);
    chk("out hold", quotient, 32'hFFFF_FFFF);
    finish_op("9/3", 32'd3, 0, 32'd3, 32'd0, 1'b0);

    // inputs change at E5, extra start at E10: both ignored
    launch(32'd1000, 32'd10);
    for (int e = 1; e <= 9; e++) begin
      @(posedge clk);
      #1;
      if (e == 5) begin
        dividend = $urandom;
        divisor  = $urandom;
      end
    end
    @(negedge clk);
    dividend = 32'd7;
    divisor  = 32'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    finish_op("ignore", 32'd10, 10, 32'd100, 32'd0, 1'b0);

    // asynchronous reset mid-iteration
    launch(32'd1000, 32'd3);
    repeat (15) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("areset busy/done", {busy, done, div_by_zero}, 3'b000);
    chk("areset result", result, 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done || busy) saw_done = 1'b1;
    end
    chk("no done after reset", saw_done, 1'b0);
    launch(32'd20, 32'd6);
    finish_op("20/6", 32'd6, 0, 32'd3, 32'd2, 1'b0);

    // random operands against the model
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 7);
      a = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      case (sel)
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = $urandom_range(1, 15);
        3: b = -$urandom_range(1, 15);
        4: b = 32'h8000_0000;
        default: b = $urandom;
      endcase
      model(a, b, eq, er, ez);
      launch(a, b);
      finish_op($sformatf("rnd%0d", i), b, 0, eq, er, ez);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
